// File: rtl/led_sequencer.sv
// led_sequencer
//   Parametrised LED pattern engine. A WIDTH-bit pattern register is advanced
//   at a programmable rate (free-run, div+1 clocks per advance) or by single
//   steps, in one of four modes: rotate left, rotate right, bounce, binary count.
//
// Ports
//   clk       clock
//   rst       asynchronous, active-high reset
//   enable    free-run advance at the divided rate
//   mode      0 rotate left, 1 rotate right, 2 bounce, 3 binary count
//   div       advance period minus one, in clk cycles
//   step      single-cycle advance when enable=0 (ignored while enable=1)
//   load      load pattern from load_val (overrides a coincident advance)
//   load_val  pattern to load
//   led       LED drive, inverted pattern when ACTIVE_LOW=1
//   tick      one-cycle strobe marking the first cycle of a new pattern
//   dir       bounce direction: 0 toward MSB, 1 toward LSB
module led_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV_W      = 24,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             dir
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             cnt_done;
  logic             adv;
  mode_e            mode_sel;

  always_comb begin
    mode_sel = mode_e'(mode);
    // >= rather than == so a div lowered below the running count fires at once
    cnt_done = (cnt_q >= div);
    adv      = enable ? cnt_done : step;
  end

  always_comb begin
    pat_d  = pat_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = adv & ~load;

    if (!enable || cnt_done || load) begin
      cnt_d = '0;
    end

    if (load) begin
      pat_d = load_val;
      dir_d = 1'b0;
    end else if (adv) begin
      unique case (mode_sel)
        MODE_ROL:   pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        MODE_ROR:   pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
        MODE_BOUNCE: begin
          // Turn around on reaching an end so each end is shown for one advance
          if (!dir_q) begin
            if (pat_q[WIDTH-1]) begin
              dir_d = 1'b1;
              pat_d = pat_q >> 1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = 1'b0;
              pat_d = pat_q << 1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        MODE_COUNT: pat_d = pat_q + WIDTH'(1);
        default:    pat_d = pat_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= WIDTH'(1);
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    led  = ACTIVE_LOW ? ~pat_q : pat_q;
    tick = tick_q;
    dir  = dir_q;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer (WIDTH=8, DIV_W=24, ACTIVE_LOW=1).
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] div = 24'd0;
  logic        step = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  led;
  logic        tick;
  logic        dir;

  int checks = 0;
  int errors = 0;

  logic [7:0] rol_tbl [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [7:0] bnc_pat [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic       bnc_dir [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  led_sequencer #(.WIDTH(8), .DIV_W(24), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .div(div),
    .step(step), .load(load), .load_val(load_val),
    .led(led), .tick(tick), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    enable = 1'b0; step = 1'b0; load = 1'b0; mode = 2'd0; div = 24'd0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    enable = 1'b1; div = 24'd0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 8'hFE || tick !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_state led=%h tick=%b dir=%b expected led=fe tick=0 dir=0", led, tick, dir);
    end
    cyc();
    rst = 1'b0; enable = 1'b0;
    cyc();
    checks++;
    if (led !== 8'hFE || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold led=%h tick=%b expected led=fe tick=0", led, tick);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] prev;
    do_reset();
    mode = 2'd0; div = 24'd3; enable = 1'b1;
    prev = 8'hFE;
    for (int a = 0; a < 8; a++) begin
      for (int k = 1; k <= 4; k++) begin
        cyc();
        checks++;
        if (k < 4) begin
          if (led !== prev || tick !== 1'b0) begin
            errors++;
            $display("FAIL rotate_hold adv=%0d k=%0d led=%h tick=%b expected led=%h tick=0", a, k, led, tick, prev);
          end
        end else begin
          if (led !== rol_tbl[a] || tick !== 1'b1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL rotate_adv adv=%0d led=%h tick=%b dir=%b expected led=%h tick=1 dir=0", a, led, tick, dir, rol_tbl[a]);
          end
          prev = rol_tbl[a];
        end
      end
    end
  endtask

  task automatic test_rotate_right();
    do_reset();
    mode = 2'd1; step = 1'b1;
    cyc();
    step = 1'b0;
    checks++;
    if (led !== 8'h7F || tick !== 1'b1) begin
      errors++;
      $display("FAIL rotate_right led=%h tick=%b expected led=7f tick=1", led, tick);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    mode = 2'd2; div = 24'd0; enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      checks++;
      if (led !== ~bnc_pat[i] || dir !== bnc_dir[i] || tick !== 1'b1) begin
        errors++;
        $display("FAIL bounce i=%0d led=%h dir=%b tick=%b expected led=%h dir=%b tick=1",
                 i, led, dir, tick, ~bnc_pat[i], bnc_dir[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_count_step();
    logic [7:0] exp_pat [3] = '{8'hFF, 8'h00, 8'h01};
    do_reset();
    mode = 2'd3; load = 1'b1; load_val = 8'hFE;
    cyc();
    load = 1'b0;
    checks++;
    if (led !== 8'h01 || tick !== 1'b0) begin
      errors++;
      $display("FAIL count_load led=%h tick=%b expected led=01 tick=0", led, tick);
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++;
      if (led !== ~exp_pat[i] || tick !== 1'b1) begin
        errors++;
        $display("FAIL count_step i=%0d led=%h tick=%b expected led=%h tick=1", i, led, tick, ~exp_pat[i]);
      end
      cyc();
      checks++;
      if (led !== ~exp_pat[i] || tick !== 1'b0) begin
        errors++;
        $display("FAIL count_gap i=%0d led=%h tick=%b expected led=%h tick=0", i, led, tick, ~exp_pat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // from pat=01 in count mode: held step advances every cycle
    step = 1'b1;
    cyc();
    checks++;
    if (led !== ~8'h02 || tick !== 1'b1) begin
      errors++;
      $display("FAIL step_held1 led=%h tick=%b expected led=fd tick=1", led, tick);
    end
    cyc();
    checks++;
    if (led !== ~8'h03 || tick !== 1'b1) begin
      errors++;
      $display("FAIL step_held2 led=%h tick=%b expected led=fc tick=1", led, tick);
    end
    // step ignored while enable=1
    enable = 1'b1; div = 24'd100;
    cyc();
    cyc();
    checks++;
    if (led !== ~8'h03 || tick !== 1'b0) begin
      errors++;
      $display("FAIL step_ignored led=%h tick=%b expected led=fc tick=0", led, tick);
    end
    step = 1'b0; enable = 1'b0;
  endtask

  task automatic test_load_adv();
    do_reset();
    mode = 2'd0; div = 24'd3; enable = 1'b1;
    cyc(); cyc(); cyc();
    load = 1'b1; load_val = 8'hA5;
    cyc();
    load = 1'b0;
    checks++;
    if (led !== 8'h5A || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_over_adv led=%h tick=%b expected led=5a tick=0", led, tick);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (k < 4) begin
        if (led !== 8'h5A || tick !== 1'b0) begin
          errors++;
          $display("FAIL load_period k=%0d led=%h tick=%b expected led=5a tick=0", k, led, tick);
        end
      end else if (led !== 8'hB4 || tick !== 1'b1) begin
        errors++;
        $display("FAIL load_next_adv led=%h tick=%b expected led=b4 tick=1", led, tick);
      end
    end
  endtask

  task automatic test_div_change();
    logic [7:0] exp_led [2] = '{8'hFB, 8'hF7};
    do_reset();
    mode = 2'd0; div = 24'd100; enable = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    checks++;
    if (led !== 8'hFE || tick !== 1'b0) begin
      errors++;
      $display("FAIL div_pre led=%h tick=%b expected led=fe tick=0", led, tick);
    end
    div = 24'd10;
    cyc();
    checks++;
    if (led !== 8'hFD || tick !== 1'b1) begin
      errors++;
      $display("FAIL div_lowered led=%h tick=%b expected led=fd tick=1", led, tick);
    end
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 11; k++) begin
        cyc();
        if (k == 10 || k == 11) begin
          checks++;
          if (k == 10 && tick !== 1'b0) begin
            errors++;
            $display("FAIL div_period_early p=%0d tick=%b expected tick=0", p, tick);
          end
          if (k == 11 && (led !== exp_led[p] || tick !== 1'b1)) begin
            errors++;
            $display("FAIL div_period p=%0d led=%h tick=%b expected led=%h tick=1", p, led, tick, exp_led[p]);
          end
        end
      end
    end
  endtask

  task automatic test_enable_toggle();
    do_reset();
    mode = 2'd0; div = 24'd3; enable = 1'b1;
    cyc(); cyc();
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (k < 4 && (led !== 8'hFE || tick !== 1'b0)) begin
        errors++;
        $display("FAIL reenable_hold k=%0d led=%h tick=%b expected led=fe tick=0", k, led, tick);
      end
      if (k == 4 && (led !== 8'hFD || tick !== 1'b1)) begin
        errors++;
        $display("FAIL reenable_adv led=%h tick=%b expected led=fd tick=1", led, tick);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    mode = 2'd2; div = 24'd0; enable = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    checks++;
    if (led !== ~8'h20 || dir !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre led=%h dir=%b expected led=df dir=1", led, dir);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 8'hFE || dir !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async led=%h dir=%b tick=%b expected led=fe dir=0 tick=0", led, dir, tick);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (led !== 8'hFD || dir !== 1'b0 || tick !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_resume led=%h dir=%b tick=%b expected led=fd dir=0 tick=1", led, dir, tick);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_rotate_right();
    test_bounce();
    test_count_step();
    test_back_to_back();
    test_load_adv();
    test_div_change();
    test_enable_toggle();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
